shift_ctrl: RTL

- Sequencing and arbitration controller for the 32-bit one-hot-select shifter datapath (`s`, `din` -> `dleftout`, `drightout`).
- Accepts shift requests from two requesters over valid/ready: port 0 is the execute-stage ALU, port 1 is the multi-cycle/CSR unit.
- Arbitrates between them round-robin, decodes the 5-bit shift amount to the one-hot select, and drives the external shifter.
- Registers the shifter output, applies SRA sign fill, and returns the result tagged with the winning port over a valid/ready response channel.

---
 rtl/shift_pkg.sv | 18 +
 rtl/rr_arb2.sv | 24 ++
 rtl/shift_ctrl.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/shift_pkg.sv
// Shared types and constants for the shifter sequencing controller.
package shift_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    SLL = 2'b00,
    SRL = 2'b01,
    SRA = 2'b10
  } shift_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } ctrl_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: a lone request always wins, a tie goes to ptr.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt,
  output logic       gnt_id
);

  always_comb begin
    gnt_id = 1'b0;
    case (req)
      2'b01:   gnt_id = 1'b0;
      2'b10:   gnt_id = 1'b1;
      2'b11:   gnt_id = ptr;
      default: gnt_id = 1'b0;
    endcase
  end

  always_comb begin
    gnt = 2'b00;
    if (req != 2'b00) gnt = gnt_id ? 2'b10 : 2'b01;
  end

endmodule

// File: rtl/shift_ctrl.sv
// Arbitrates two shift requesters, drives the external one-hot shifter for one
// cycle, then holds the sign-corrected result on a valid/ready response port.
//
// Handshakes: a transfer happens on a rising edge where valid & ready are both
// high; valid never waits on ready, and an offered rsp_* value stays stable
// until it is taken.
module shift_ctrl #(
  parameter int XLEN = 32,
  parameter int NREQ = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [1:0]             req_op0,
  input  logic [1:0]             req_op1,
  input  logic [4:0]             req_shamt0,
  input  logic [4:0]             req_shamt1,
  input  logic [XLEN-1:0]        req_data0,
  input  logic [XLEN-1:0]        req_data1,
  output logic [XLEN-1:0]        sh_s,
  output logic [XLEN-1:0]        sh_din,
  input  logic [XLEN-1:0]        sh_left,
  input  logic [XLEN-1:0]        sh_right,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic                   rsp_id,
  output logic [XLEN-1:0]        rsp_data,
  output logic                   busy,
  output shift_pkg::ctrl_state_t dbg_state,
  output logic                   dbg_rr_ptr
);
  import shift_pkg::*;

  ctrl_state_t     state_q, state_d;
  logic            rr_ptr_q, rr_ptr_d;
  logic [1:0]      op_q, op_d;
  logic [4:0]      shamt_q, shamt_d;
  logic [XLEN-1:0] data_q, data_d;
  logic            id_q, id_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic            rsp_id_q, rsp_id_d;
  logic [XLEN-1:0] rsp_data_q, rsp_data_d;

  logic [1:0]      gnt;
  logic            gnt_id;
  logic            accept;
  logic [XLEN-1:0] sra_fill;
  logic [XLEN-1:0] shift_res;

  rr_arb2 u_arb (
    .req    (req_valid),
    .ptr    (rr_ptr_q),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  assign accept = (state_q == IDLE) && (gnt != 2'b00);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= 1'b0;
      op_q        <= 2'b00;
      shamt_q     <= 5'd0;
      data_q      <= '0;
      id_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      op_q        <= op_d;
      shamt_q     <= shamt_d;
      data_q      <= data_d;
      id_q        <= id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SHIFT;
      SHIFT:   state_d = HOLD;
      HOLD:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // SRA: the shifter only does a logical right shift, so fill vacated MSBs here.
  always_comb begin
    sra_fill = data_q[XLEN-1] ? ~({XLEN{1'b1}} >> shamt_q) : '0;
    case (op_q)
      SRL:     shift_res = sh_right;
      SRA:     shift_res = sh_right | sra_fill;
      default: shift_res = sh_left;
    endcase
  end

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    op_d        = op_q;
    shamt_d     = shamt_q;
    data_d      = data_q;
    id_d        = id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          id_d    = gnt_id;
          op_d    = gnt_id ? req_op1 : req_op0;
          shamt_d = gnt_id ? req_shamt1 : req_shamt0;
          data_d  = gnt_id ? req_data1 : req_data0;
          if (req_valid == 2'b11) rr_ptr_d = ~gnt_id;
        end
      end
      SHIFT: begin
        rsp_valid_d = 1'b1;
        rsp_id_d    = id_q;
        rsp_data_d  = shift_res;
      end
      HOLD: begin
        if (rsp_ready) rsp_valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  // Shifter inputs are parked at zero outside SHIFT to keep it quiet.
  always_comb begin
    req_ready  = (state_q == IDLE) ? gnt : 2'b00;
    sh_s       = (state_q == SHIFT) ? (XLEN'(1) << shamt_q) : '0;
    sh_din     = (state_q == SHIFT) ? data_q : '0;
    busy       = (state_q != IDLE);
    rsp_valid  = rsp_valid_q;
    rsp_id     = rsp_id_q;
    rsp_data   = rsp_data_q;
    dbg_state  = state_q;
    dbg_rr_ptr = rr_ptr_q;
  end

endmodule
